mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Iterative HI/LO multiply/divide unit. Sits directly downstream of the register-file read ports of the single-cycle MIPS core.
- Consumes rs/rt operands for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Produces the HI/LO values that the core's writeback mux selects for MFHI/MFLO.
- Exposes busy so the core can stall the PC when MFHI/MFLO or a new mul/div arrives while an operation is in flight.

Parameters:
WIDTH, 32, operand/result width; HI and LO are each WIDTH bits. Iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
clk_enable  input  1  when low, all state holds (no iteration, no start, no write)
start  input  1  request; sampled on an enabled edge when not busy
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 ignored
op_a  input  WIDTH  rs value (multiplicand / dividend / MTHI/MTLO source)
op_b  input  WIDTH  rt value (multiplier / divisor)
busy  output  1  high while a mul/div is iterating
done  output  1  one-enabled-cycle pulse when a mul/div result lands in HI/LO
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Single clock, clk. reset is synchronous and active-high, and overrides everything.
- On reset: state=IDLE; busy=0, done=0, hi=0, lo=0; counter=0.
- All registers update only on rising edges where clk_enable=1 or reset=1.
- States: IDLE, MUL, DIV.
- IDLE, start=1, op=MTHI/MTLO: hi (resp. lo) := op_a at that edge. State stays IDLE, busy stays 0, done stays 0.
- IDLE, start=1, op=MULT/MULTU: latch operands at edge E0, then go to MUL.
  - MULT: latch |op_a|, |op_b| and the result sign (sign_a XOR sign_b).
  - MULTU: latch raw operands, sign=0.
  - busy=1 from after E0.
- IDLE, start=1, op=DIV/DIVU: same latching (DIV also records the dividend sign), go to DIV.
- IDLE, start=1, op=110/111: no effect.
- MUL: radix-2 shift-add, one multiplier bit per enabled edge, 2*WIDTH accumulator.
- DIV: restoring shift-subtract, one quotient bit per enabled edge.
- Counter runs 0..WIDTH-1.
- Latency: the WIDTH-th iteration edge (E32 for WIDTH=32) does the following at once:
  - writes the final sign-corrected result to hi/lo;
  - clears busy and returns to IDLE;
  - sets done=1.
- done clears on the next enabled edge.
- busy is therefore high for exactly 32 enabled cycles.
- hi/lo keep their previous values throughout iteration and change only at completion.
- Multiply result: {hi,lo} = full 64-bit product.
  - Signed: two's-complement negate of the 64-bit magnitude when sign=1.
- Divide result: lo=quotient, hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (op_b=0), DIV and DIVU: lo=0xFFFFFFFF, hi=op_a (original, unsigned view). Takes the full 32 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- start while busy: ignored entirely. Operands, op and hi/lo are unaffected; the core guarantees stalling.
- MTHI/MTLO while busy: ignored.
- start on the completion edge: ignored, because busy=1 at that edge. It is accepted on the next enabled edge.
- clk_enable=0 mid-operation: counter, accumulators, busy and done all freeze. Completion slips by the number of disabled cycles.
- reset mid-operation: immediate return to IDLE with all outputs zero. The partial result is discarded.
- Outputs are registered; no combinational path exists from inputs to outputs.

Test Plan:
- Reset, then MULTU op_a=0xFFFFFFFF op_b=0xFFFFFFFF -> busy high 32 cycles; then hi=0xFFFFFFFE, lo=0x00000001, done pulses exactly one cycle.
- MULT op_a=0xFFFFFFFD (-3), op_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=0x0000000E, hi=0x00000002.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0xCAFEBABE while idle -> hi=0xCAFEBABE next edge, busy stays 0. Start MULTU, assert start with DIVU at busy cycle 5 -> ignored, MULTU result correct. Reset at busy cycle 10 -> busy=0, hi=lo=0 next edge.
- Start MULTU 6x7, drop clk_enable for 5 cycles mid-operation -> busy lasts 37 clock cycles; then lo=42, hi=0, done one enabled cycle.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative HI/LO multiply/divide unit for MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Ports:
//   clk, reset (sync, active-high), clk_enable (global stall)
//   start, op[2:0], op_a (rs), op_b (rt) -> request from decode/regfile
//   busy (iterating), done (one enabled-cycle completion pulse)
//   hi, lo (architectural HI/LO registers)
module mips_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_enable,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // MUL: {partial product high, remaining multiplier bits}
   // DIV: {partial remainder, dividend bits / quotient bits}
   logic [2*WIDTH-1:0] acc_q, acc_d;
   // multiplicand magnitude for MUL, divisor magnitude for DIV
   logic [WIDTH-1:0]   oper_q, oper_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   orig_q, orig_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               is_signed;
   logic               is_mul;
   logic               is_div;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_abs;
   logic [WIDTH-1:0]   b_abs;
   logic               last;

   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] div_next;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;

   // ---------------- request decode ----------------
   always_comb begin
      is_signed = (op == OP_MULT) || (op == OP_DIV);
      is_mul    = (op == OP_MULT) || (op == OP_MULTU);
      is_div    = (op == OP_DIV)  || (op == OP_DIVU);
      a_neg     = is_signed && op_a[WIDTH-1];
      b_neg     = is_signed && op_b[WIDTH-1];
      a_abs     = a_neg ? (~op_a + 1'b1) : op_a;
      b_abs     = b_neg ? (~op_b + 1'b1) : op_b;
      last      = (cnt_q == CW'(WIDTH - 1));
   end

   // ---------------- iteration datapath ----------------
   always_comb begin
      // shift-add: add multiplicand if current multiplier LSB is set
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + (acc_q[0] ? {1'b0, oper_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
      mul_res  = neg_q ? (~mul_next + 1'b1) : mul_next;

      // restoring divide: trial subtract on the shifted-left remainder
      div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]}
                - {1'b0, oper_q};
      if (!div_trial[WIDTH]) begin
         div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_next = {acc_q[2*WIDTH-2:0], 1'b0};
      end
      quot = neg_q  ? (~div_next[WIDTH-1:0] + 1'b1)
                    : div_next[WIDTH-1:0];
      rem  = rneg_q ? (~div_next[2*WIDTH-1:WIDTH] + 1'b1)
                    : div_next[2*WIDTH-1:WIDTH];
   end

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else if (clk_enable) begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && is_mul) begin
               state_d = S_MUL;
            end else if (start && is_div) begin
               state_d = S_DIV;
            end
         end
         S_MUL, S_DIV: begin
            if (last) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- output / datapath next values ----------------
   always_comb begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      oper_d = oper_q;
      neg_d  = neg_q;
      rneg_d = rneg_q;
      dz_d   = dz_q;
      orig_d = orig_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               unique case (1'b1)
                  is_mul: begin
                     oper_d = a_abs;
                     acc_d  = {{WIDTH{1'b0}}, b_abs};
                     neg_d  = a_neg ^ b_neg;
                     rneg_d = 1'b0;
                     dz_d   = 1'b0;
                     orig_d = op_a;
                     cnt_d  = '0;
                  end
                  is_div: begin
                     oper_d = b_abs;
                     acc_d  = {{WIDTH{1'b0}}, a_abs};
                     neg_d  = a_neg ^ b_neg;
                     rneg_d = a_neg;
                     dz_d   = (op_b == '0);
                     orig_d = op_a;
                     cnt_d  = '0;
                  end
                  (op == OP_MTHI): hi_d = op_a;
                  (op == OP_MTLO): lo_d = op_a;
                  default: ;
               endcase
            end
         end
         S_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               hi_d   = mul_res[2*WIDTH-1:WIDTH];
               lo_d   = mul_res[WIDTH-1:0];
               done_d = 1'b1;
               cnt_d  = '0;
            end
         end
         S_DIV: begin
            acc_d = div_next;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               // divide by zero reports the raw dividend and all-ones quotient
               hi_d   = dz_q ? orig_q : rem;
               lo_d   = dz_q ? '1 : quot;
               done_d = 1'b1;
               cnt_d  = '0;
            end
         end
         default: ;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         acc_q  <= '0;
         oper_q <= '0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         dz_q   <= 1'b0;
         orig_q <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else if (clk_enable) begin
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         oper_q <= oper_d;
         neg_q  <= neg_d;
         rneg_q <= rneg_d;
         dz_q   <= dz_d;
         orig_q <= orig_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb_mips_muldiv_unit: randomized and directed checks of mips_muldiv_unit
// against an arithmetic reference model.
module tb_mips_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_enable = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int failures = 0;

   localparam int TIMEOUT = 200;

   mips_muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk),
      .reset(reset),
      .clk_enable(clk_enable),
      .start(start),
      .op(op),
      .op_a(op_a),
      .op_b(op_b),
      .busy(busy),
      .done(done),
      .hi(hi),
      .lo(lo)
   );

   always #5 clk = ~clk;

   // returns {hi, lo}
   function automatic logic [63:0] ref_model(input logic [2:0] o,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p, qv, rv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p = '0;
      case (o)
         3'd0: begin
            q = sa * sb;
            p = q;
         end
         3'd1: p = {32'd0, a} * {32'd0, b};
         3'd2: begin
            if (b == 0) p = {a, 32'hFFFFFFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               qv = q;
               rv = r;
               p = {rv[31:0], qv[31:0]};
            end
         end
         3'd3: begin
            if (b == 0) p = {a, 32'hFFFFFFFF};
            else p = {a % b, a / b};
         end
         default: p = '0;
      endcase
      return p;
   endfunction

   task automatic issue(input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      op = o;
      op_a = a;
      op_b = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // issue one mul/div and verify latency, result and done pulse
   task automatic run_and_check_op(input string nm, input logic [2:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
      int n;
      logic [63:0] exp;
      logic [31:0] hi0, lo0;
      exp = ref_model(o, a, b);
      hi0 = hi;
      lo0 = lo;
      issue(o, a, b);
      n = 0;
      while (busy && n < TIMEOUT) begin
         n++;
         if (n == 16) begin
            checks++;
            if (hi !== hi0 || lo !== lo0 || done !== 1'b0) begin
               failures++;
               $display("FAIL %s_hold: hi=%h lo=%h done=%b need hi=%h lo=%h done=0",
                        nm, hi, lo, done, hi0, lo0);
            end
         end
         @(negedge clk);
      end
      checks++;
      if (n !== 32) begin
         failures++;
         $display("FAIL %s_busy: cycles=%0d need 32", nm, n);
      end
      checks++;
      if ({hi, lo} !== exp || done !== 1'b1) begin
         failures++;
         $display("FAIL %s_result: op=%0d a=%h b=%h got hi=%h lo=%h done=%b need hi=%h lo=%h done=1",
                  nm, o, a, b, hi, lo, done, exp[63:32], exp[31:0]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL %s_done_pulse: done=%b need 0", nm, done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
         failures++;
         $display("FAIL reset: busy=%b done=%b hi=%h lo=%h need all zero",
                  busy, done, hi, lo);
      end
      reset = 1'b0;
   endtask

   task automatic test_directed();
      run_and_check_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      checks++;
      if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
         failures++;
         $display("FAIL multu_max_const: hi=%h lo=%h need fffffffe 00000001",
                  hi, lo);
      end
      run_and_check_op("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd7);
      run_and_check_op("mult_min", 3'd0, 32'h80000000, 32'h80000000);
      checks++;
      if (hi !== 32'h40000000 || lo !== 32'h0) begin
         failures++;
         $display("FAIL mult_min_const: hi=%h lo=%h need 40000000 00000000",
                  hi, lo);
      end
      run_and_check_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
      checks++;
      if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
         failures++;
         $display("FAIL div_neg_const: hi=%h lo=%h need ffffffff fffffffd",
                  hi, lo);
      end
      run_and_check_op("divu_100_7", 3'd3, 32'd100, 32'd7);
      run_and_check_op("divu_zero", 3'd3, 32'h1234, 32'd0);
      run_and_check_op("div_zero_neg", 3'd2, 32'hFFFFFF00, 32'd0);
      run_and_check_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
      checks++;
      if (hi !== 32'h0 || lo !== 32'h80000000) begin
         failures++;
         $display("FAIL div_ovf_const: hi=%h lo=%h need 00000000 80000000",
                  hi, lo);
      end
   endtask

   task automatic test_mthi_mtlo();
      logic [31:0] lo0;
      lo0 = lo;
      issue(3'd4, 32'hCAFEBABE, 32'h0);
      checks++;
      if (hi !== 32'hCAFEBABE || lo !== lo0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b need cafebabe %h 0 0",
                  hi, lo, busy, done, lo0);
      end
      issue(3'd5, 32'h13579BDF, 32'h0);
      checks++;
      if (hi !== 32'hCAFEBABE || lo !== 32'h13579BDF || busy !== 1'b0) begin
         failures++;
         $display("FAIL mtlo: hi=%h lo=%h busy=%b need cafebabe 13579bdf 0",
                  hi, lo, busy);
      end
      issue(3'd6, 32'h11111111, 32'h2);
      checks++;
      if (hi !== 32'hCAFEBABE || lo !== 32'h13579BDF || busy !== 1'b0) begin
         failures++;
         $display("FAIL op_ignored: hi=%h lo=%h busy=%b need cafebabe 13579bdf 0",
                  hi, lo, busy);
      end
   endtask

   task automatic test_start_while_busy();
      int n;
      logic [63:0] exp;
      exp = ref_model(3'd1, 32'h89ABCDEF, 32'h12345677);
      issue(3'd1, 32'h89ABCDEF, 32'h12345677);
      n = 0;
      while (busy && n < TIMEOUT) begin
         n++;
         if (n == 5) begin
            start = 1'b1;
            op = 3'd3;
            op_a = 32'd1000;
            op_b = 32'd3;
         end else if (n == 7) begin
            op = 3'd4;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (n !== 32 || {hi, lo} !== exp || done !== 1'b1) begin
         failures++;
         $display("FAIL busy_ignore: cycles=%0d hi=%h lo=%h done=%b need 32 %h %h 1",
                  n, hi, lo, done, exp[63:32], exp[31:0]);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_ignore_idle: busy=%b need 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      issue(3'd1, 32'hFFFF0000, 32'h0000FFFF);
      n = 1;
      while (n < 10) begin
         @(negedge clk);
         n++;
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || hi !== '0 || lo !== '0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: busy=%b hi=%h lo=%h done=%b need 0 0 0 0",
                  busy, hi, lo, done);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (hi !== '0 || lo !== '0 || done !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_discard: hi=%h lo=%h done=%b need 0 0 0",
                  hi, lo, done);
      end
   endtask

   task automatic test_clk_enable();
      int n;
      issue(3'd1, 32'd6, 32'd7);
      n = 0;
      while (busy && n < TIMEOUT) begin
         n++;
         clk_enable = (n >= 10 && n < 15) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      clk_enable = 1'b1;
      checks++;
      if (n !== 37 || hi !== 32'd0 || lo !== 32'd42 || done !== 1'b1) begin
         failures++;
         $display("FAIL clk_enable: cycles=%0d hi=%h lo=%h done=%b need 37 0 2a 1",
                  n, hi, lo, done);
      end
      clk_enable = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL clk_enable_done_hold: done=%b need 1", done);
      end
      clk_enable = 1'b1;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         failures++;
         $display("FAIL clk_enable_done_clear: done=%b need 0", done);
      end
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'h0;
         1: v = 32'h80000000;
         2: v = 32'hFFFFFFFF;
         3: v = $urandom_range(0, 20);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic test_random();
      logic [2:0] o;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 3));
         a = pick_operand();
         b = pick_operand();
         run_and_check_op("random", o, a, b);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mthi_mtlo();
      test_start_while_busy();
      test_reset_mid();
      test_clk_enable();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
